pe_layer_sequencer: RTL and testbench
=====================================

Name: pe_layer_sequencer

Overview:
- Per-layer control sequencer that drives the controller-side inputs of the low-power PE array for one conv/max-pool/MAC layer.
- Latches a layer descriptor on start. Generates the LDM read-address stream (ports A/B), enable, padding and stride-parity controls, the store-bank selector and the PE enable.
- Drains the ALU pipeline, then pulses layer_done so every PE rewinds its write-back pointer.
- Sits between the top-level layer scheduler and the broadcast control bus of all PEs.

Parameters:
- LDM_ADDR_BITS, 6, LDM word-address width.
- S_LDM_BITS, 2, source-bank select width.
- D_LDM_BITS, 2, destination-bank select width.
- SA_LDM_BITS, 6, store-offset width.
- ALU_CFG_BITS, 4, ALU config width; MSB is the ReLU enable.
- DRAIN_CYCLES, 4, cycles held after the last read so in-flight ALU results retire.

Ports:
- CLK  in  1  clock.
- RST  in  1  reset; asynchronous, active-low.
- start_in  in  1  one-cycle pulse; accepted only in IDLE.
- abort_in  in  1  synchronous abort; forces FLUSH from any busy state.
- cfg_in  in  ALU_CFG_BITS  ALU opcode plus ReLU bit for the layer.
- src_bank_in  in  S_LDM_BITS  LDM bank to read.
- dst_bank_in  in  D_LDM_BITS  LDM bank to store.
- store_ofs_in  in  SA_LDM_BITS  store base offset.
- base_addr_in  in  LDM_ADDR_BITS  first read address.
- out_len_in  in  LDM_ADDR_BITS  outputs per pass, 1..63; 0 means no work.
- kernel_in  in  2  reads per output, 1..3; 0 is treated as 1.
- stride_in  in  1  0 = stride 1; 1 = stride 2, run as two parity passes.
- pad_in  in  1  first read of each pass is a padding read.
- busy_out  out  1  high from start accepted to done.
- done_out  out  1  one-cycle pulse when the layer ends.
- En_out  out  1  PE enable.
- layer_done_out  out  1  one-cycle PE rewind pulse.
- CFG_out  out  ALU_CFG_BITS  latched cfg.
- Parity_PE_Selection_out  out  1  active parity during stride-2 passes.
- Stride_out  out  1  latched stride.
- Padding_Read_out  out  1  padding-read qualifier.
- CTRL_LDM_addra_out  out  S_LDM_BITS+LDM_ADDR_BITS  {src_bank, read address}.
- CTRL_LDM_addrb_out  out  S_LDM_BITS+LDM_ADDR_BITS  {src_bank, read address + 1}.
- CTRL_LDM_ena_out, CTRL_LDM_enb_out  out  1  read enables.
- CTRL_LDM_wea_out, CTRL_LDM_web_out  out  1  tied 0.
- CTRL_LDM_Store_out  out  D_LDM_BITS+SA_LDM_BITS  {dst_bank, store_ofs}.
- CTRL_LDM_addra_Incr_out  out  1  high on every non-first read of an output window.

Behaviour:
- Reset (RST low, async):
  - State is IDLE and all counters are 0.
  - Every output is 0 except CFG_out, CTRL_LDM_Store_out and the address outputs, which reset to 0 as well.
- All outputs are registered; there is no combinational input-to-output path.
- States: IDLE, LOAD, RUN, DRAIN, DONE, FLUSH.
- IDLE:
  - On start_in, latch all *_in descriptor fields and go to LOAD.
  - If out_len_in == 0, go straight to DONE instead.
  - Start pulses in any other state are ignored.
- LOAD (1 cycle):
  - Clear out_idx, k_idx and pass, setting parity to 0.
  - Set busy_out = 1 and En_out = 1.
  - Drive CFG_out, Stride_out and CTRL_LDM_Store_out from the latched fields.
- RUN (one read per cycle):
  - Read address = base + out_idx*(1+stride) + k_idx, modulo 2^LDM_ADDR_BITS; wrap is allowed and not flagged.
  - addrb = addra + 1, with the same wrap.
  - ena = enb = 1.
  - Padding_Read_out = pad AND out_idx==0 AND k_idx==0.
  - CTRL_LDM_addra_Incr_out = (k_idx != 0).
  - k_idx counts 0..K-1. At K-1 it resets to 0 and out_idx increments.
  - When out_idx == out_len-1 and k_idx == K-1:
    - If stride = 1, or this is parity pass 1, go to DRAIN.
    - Otherwise set parity to 1, clear out_idx, and stay in RUN. There is no idle cycle between passes.
- DRAIN:
  - ena/enb = 0 and En_out = 1.
  - Count DRAIN_CYCLES cycles, then go to DONE.
- DONE (1 cycle):
  - layer_done_out = 1, done_out = 1, En_out = 0.
  - Next cycle: IDLE, busy_out = 0, parity = 0.
- FLUSH:
  - Entered when abort_in is sampled high in LOAD, RUN or DRAIN.
  - Drops ena/enb and En_out immediately (registered, so effective the next cycle).
  - Next cycle goes to DONE, giving the same layer_done/done pulses so the PEs rewind.
  - abort_in in IDLE or DONE is ignored.
- Simultaneous abort_in and a RUN terminal condition: abort wins.
- Total RUN cycles = out_len * K * (1 + stride).
- Latency:
  - start → first ena = 2 cycles (LOAD, then RUN registered output).
  - Last ena → layer_done = DRAIN_CYCLES + 1 cycles.

Test Plan:
- Stride-1 conv: base=4, out_len=3, K=3, stride=0, pad=0 → addra sequence 4,5,6,5,6,7,6,7,8; Incr pattern 0,1,1 per output; 9 ena cycles; layer_done 5 cycles after the last ena.
- Stride-2 two-pass: base=0, out_len=2, K=2, stride=1 → parity 0 reads 0,1,2,3 then parity 1 reads 0,1,2,3; 8 contiguous ena cycles; Stride_out=1 throughout.
- Padding: pad=1, out_len=2, K=3, stride=1 → Padding_Read_out high on exactly two cycles, the first read of each parity pass.
- Wrap and zero length: base=62, out_len=2, K=2 → addra 62,63,63,0 and addrb 63,0,0,1. Separately, out_len=0 → done_out 1 cycle after start with no ena.
- Abort: abort_in on the 3rd RUN cycle → ena low from the next cycle, then layer_done/done pulse one cycle later, busy_out low the cycle after. A start_in pulse issued while busy has no effect.
- Async reset mid-RUN: RST low → all outputs 0 immediately. After release, a new start runs a full layer correctly.

Source files
------------

// File: rtl/pe_layer_sequencer_if.sv
// Scheduler-facing layer descriptor/handshake and the PE-array broadcast control bus.
// The sequencer connects through the slave modport.
interface pe_layer_sequencer_if #(
  parameter int unsigned LDM_ADDR_BITS = 6,
  parameter int unsigned S_LDM_BITS    = 2,
  parameter int unsigned D_LDM_BITS    = 2,
  parameter int unsigned SA_LDM_BITS   = 6,
  parameter int unsigned ALU_CFG_BITS  = 4
);
  logic                                start_in;
  logic                                abort_in;
  logic [ALU_CFG_BITS-1:0]             cfg_in;
  logic [S_LDM_BITS-1:0]               src_bank_in;
  logic [D_LDM_BITS-1:0]               dst_bank_in;
  logic [SA_LDM_BITS-1:0]              store_ofs_in;
  logic [LDM_ADDR_BITS-1:0]            base_addr_in;
  logic [LDM_ADDR_BITS-1:0]            out_len_in;
  logic [1:0]                          kernel_in;
  logic                                stride_in;
  logic                                pad_in;

  logic                                busy_out;
  logic                                done_out;
  logic                                En_out;
  logic                                layer_done_out;
  logic [ALU_CFG_BITS-1:0]             CFG_out;
  logic                                Parity_PE_Selection_out;
  logic                                Stride_out;
  logic                                Padding_Read_out;
  logic [S_LDM_BITS+LDM_ADDR_BITS-1:0] CTRL_LDM_addra_out;
  logic [S_LDM_BITS+LDM_ADDR_BITS-1:0] CTRL_LDM_addrb_out;
  logic                                CTRL_LDM_ena_out;
  logic                                CTRL_LDM_enb_out;
  logic                                CTRL_LDM_wea_out;
  logic                                CTRL_LDM_web_out;
  logic [D_LDM_BITS+SA_LDM_BITS-1:0]   CTRL_LDM_Store_out;
  logic                                CTRL_LDM_addra_Incr_out;

  modport master (
    output start_in, abort_in, cfg_in, src_bank_in, dst_bank_in, store_ofs_in,
           base_addr_in, out_len_in, kernel_in, stride_in, pad_in,
    input  busy_out, done_out, En_out, layer_done_out, CFG_out, Parity_PE_Selection_out,
           Stride_out, Padding_Read_out, CTRL_LDM_addra_out, CTRL_LDM_addrb_out,
           CTRL_LDM_ena_out, CTRL_LDM_enb_out, CTRL_LDM_wea_out, CTRL_LDM_web_out,
           CTRL_LDM_Store_out, CTRL_LDM_addra_Incr_out
  );

  modport slave (
    input  start_in, abort_in, cfg_in, src_bank_in, dst_bank_in, store_ofs_in,
           base_addr_in, out_len_in, kernel_in, stride_in, pad_in,
    output busy_out, done_out, En_out, layer_done_out, CFG_out, Parity_PE_Selection_out,
           Stride_out, Padding_Read_out, CTRL_LDM_addra_out, CTRL_LDM_addrb_out,
           CTRL_LDM_ena_out, CTRL_LDM_enb_out, CTRL_LDM_wea_out, CTRL_LDM_web_out,
           CTRL_LDM_Store_out, CTRL_LDM_addra_Incr_out
  );
endinterface

// File: rtl/pe_layer_sequencer.sv
// Per-layer sequencer: latches a descriptor, streams LDM reads (one per cycle, two parity
// passes for stride 2), drains the ALU pipeline and pulses layer_done. All outputs are flops.
module pe_layer_sequencer #(
  parameter int unsigned LDM_ADDR_BITS = 6,
  parameter int unsigned S_LDM_BITS    = 2,
  parameter int unsigned D_LDM_BITS    = 2,
  parameter int unsigned SA_LDM_BITS   = 6,
  parameter int unsigned ALU_CFG_BITS  = 4,
  parameter int unsigned DRAIN_CYCLES  = 4
) (
  input logic                CLK,
  input logic                RST,
  pe_layer_sequencer_if.slave bus
);
  localparam int unsigned DrainW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DrainW-1:0] DrainLast = DrainW'(DRAIN_CYCLES - 1);
  localparam logic [LDM_ADDR_BITS-1:0] AddrOne = LDM_ADDR_BITS'(1);

  typedef logic [LDM_ADDR_BITS-1:0] addr_t;
  typedef enum logic [2:0] {StIdle, StLoad, StRun, StDrain, StDone, StFlush} state_e;

  state_e                  state_q, state_d;
  logic [ALU_CFG_BITS-1:0] cfg_q, cfg_d;
  logic [S_LDM_BITS-1:0]   src_q, src_d;
  logic [D_LDM_BITS-1:0]   dst_q, dst_d;
  logic [SA_LDM_BITS-1:0]  ofs_q, ofs_d;
  addr_t                   base_q, base_d, len_q, len_d;
  logic [1:0]              k_last_q, k_last_d;
  logic                    stride_q, stride_d, pad_q, pad_d;
  addr_t                   out_idx_q, out_idx_d;
  logic [1:0]              k_idx_q, k_idx_d;
  logic                    parity_q, parity_d;
  logic [DrainW-1:0]       drain_q, drain_d;
  logic                    busy_q, busy_d, done_q, done_d, en_q, en_d, rd_q, rd_d;
  logic                    padrd_q, padrd_d, incr_q, incr_d;
  addr_t                   addra_q, addra_d, addrb_q, addrb_d;
  logic                    last_k, last_out, run_d;
  addr_t                   rd_addr;

  always_comb begin
    state_d   = state_q;
    cfg_d     = cfg_q;
    src_d     = src_q;
    dst_d     = dst_q;
    ofs_d     = ofs_q;
    base_d    = base_q;
    len_d     = len_q;
    k_last_d  = k_last_q;
    stride_d  = stride_q;
    pad_d     = pad_q;
    out_idx_d = out_idx_q;
    k_idx_d   = k_idx_q;
    parity_d  = parity_q;
    drain_d   = drain_q;
    last_k    = (k_idx_q == k_last_q);
    last_out  = (out_idx_q == len_q - AddrOne);

    unique case (state_q)
      StIdle: begin
        if (bus.start_in) begin
          cfg_d     = bus.cfg_in;
          src_d     = bus.src_bank_in;
          dst_d     = bus.dst_bank_in;
          ofs_d     = bus.store_ofs_in;
          base_d    = bus.base_addr_in;
          len_d     = bus.out_len_in;
          // kernel 0 behaves as a 1-read window
          k_last_d  = (bus.kernel_in == 2'd0) ? 2'd0 : bus.kernel_in - 2'd1;
          stride_d  = bus.stride_in;
          pad_d     = bus.pad_in;
          out_idx_d = '0;
          k_idx_d   = '0;
          parity_d  = 1'b0;
          state_d   = (bus.out_len_in == '0) ? StDone : StLoad;
        end
      end
      StLoad: begin
        out_idx_d = '0;
        k_idx_d   = '0;
        parity_d  = 1'b0;
        state_d   = bus.abort_in ? StFlush : StRun;
      end
      StRun: begin
        if (bus.abort_in) begin
          state_d = StFlush;
        end else if (last_k) begin
          k_idx_d = '0;
          if (!last_out) begin
            out_idx_d = out_idx_q + AddrOne;
          end else if (!stride_q || parity_q) begin
            state_d = StDrain;
            drain_d = '0;
          end else begin
            // second parity pass follows with no gap
            parity_d  = 1'b1;
            out_idx_d = '0;
          end
        end else begin
          k_idx_d = k_idx_q + 2'd1;
        end
      end
      StDrain: begin
        if (bus.abort_in) begin
          state_d = StFlush;
        end else if (drain_q == DrainLast) begin
          state_d = StDone;
        end else begin
          drain_d = drain_q + DrainW'(1);
        end
      end
      StDone: begin
        state_d  = StIdle;
        parity_d = 1'b0;
      end
      StFlush: state_d = StDone;
      default: state_d = StIdle;
    endcase

    // Output flops are loaded from the next state so they describe the cycle being entered.
    run_d   = (state_d == StRun);
    busy_d  = (state_d != StIdle);
    done_d  = (state_d == StDone);
    en_d    = state_d inside {StLoad, StRun, StDrain};
    rd_d    = run_d;
    padrd_d = run_d && pad_d && (out_idx_d == '0) && (k_idx_d == '0);
    incr_d  = run_d && (k_idx_d != '0);
    rd_addr = base_d + (stride_d ? (out_idx_d << 1) : out_idx_d)
            + {{(LDM_ADDR_BITS-2){1'b0}}, k_idx_d};
    addra_d = run_d ? rd_addr : addra_q;
    addrb_d = run_d ? rd_addr + AddrOne : addrb_q;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= StIdle;
      cfg_q     <= '0;
      src_q     <= '0;
      dst_q     <= '0;
      ofs_q     <= '0;
      base_q    <= '0;
      len_q     <= '0;
      k_last_q  <= '0;
      stride_q  <= 1'b0;
      pad_q     <= 1'b0;
      out_idx_q <= '0;
      k_idx_q   <= '0;
      parity_q  <= 1'b0;
      drain_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      en_q      <= 1'b0;
      rd_q      <= 1'b0;
      padrd_q   <= 1'b0;
      incr_q    <= 1'b0;
      addra_q   <= '0;
      addrb_q   <= '0;
    end else begin
      state_q   <= state_d;
      cfg_q     <= cfg_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      ofs_q     <= ofs_d;
      base_q    <= base_d;
      len_q     <= len_d;
      k_last_q  <= k_last_d;
      stride_q  <= stride_d;
      pad_q     <= pad_d;
      out_idx_q <= out_idx_d;
      k_idx_q   <= k_idx_d;
      parity_q  <= parity_d;
      drain_q   <= drain_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      en_q      <= en_d;
      rd_q      <= rd_d;
      padrd_q   <= padrd_d;
      incr_q    <= incr_d;
      addra_q   <= addra_d;
      addrb_q   <= addrb_d;
    end
  end

  assign bus.busy_out                = busy_q;
  assign bus.done_out                = done_q;
  assign bus.layer_done_out          = done_q;
  assign bus.En_out                  = en_q;
  assign bus.CFG_out                 = cfg_q;
  assign bus.Parity_PE_Selection_out = parity_q;
  assign bus.Stride_out              = stride_q;
  assign bus.Padding_Read_out        = padrd_q;
  assign bus.CTRL_LDM_addra_out      = {src_q, addra_q};
  assign bus.CTRL_LDM_addrb_out      = {src_q, addrb_q};
  assign bus.CTRL_LDM_ena_out        = rd_q;
  assign bus.CTRL_LDM_enb_out        = rd_q;
  assign bus.CTRL_LDM_wea_out        = 1'b0;
  assign bus.CTRL_LDM_web_out        = 1'b0;
  assign bus.CTRL_LDM_Store_out      = {dst_q, ofs_q};
  assign bus.CTRL_LDM_addra_Incr_out = incr_q;
endmodule

// File: tb/tb_pe_layer_sequencer.sv
// Randomised bench for pe_layer_sequencer: a per-cycle expected trace is built from the
// layer rules (passes x outputs x window reads, drain, done) and compared cycle by cycle.
module tb_pe_layer_sequencer;
  localparam int unsigned AW = 6, SW = 2, DW = 2, OW = 6, CW = 4, DRAIN = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pe_layer_sequencer_if #(.LDM_ADDR_BITS(AW), .S_LDM_BITS(SW), .D_LDM_BITS(DW),
                          .SA_LDM_BITS(OW), .ALU_CFG_BITS(CW)) bus ();

  pe_layer_sequencer #(.LDM_ADDR_BITS(AW), .S_LDM_BITS(SW), .D_LDM_BITS(DW),
                       .SA_LDM_BITS(OW), .ALU_CFG_BITS(CW), .DRAIN_CYCLES(DRAIN)) dut (
    .CLK (clk),
    .RST (rst_n),
    .bus (bus)
  );

  typedef struct packed {
    logic       busy, done, ldone, en, ena, enb, wea, web, pad, incr, par, strd;
    logic [3:0] cfg;
    logic [7:0] store, addra, addrb;
  } obs_t;

  typedef struct {
    int cfg, src, dst, ofs, base, len, kern, stride, pad;
  } desc_t;

  int   total = 0;
  int   bad = 0;
  obs_t exp_q[$];
  obs_t obs_q[$];

  function automatic desc_t make_desc(int base, int len, int kern, int stride, int pad);
    desc_t d;
    d.cfg = int'($urandom_range(0, 15));
    d.src = int'($urandom_range(0, 3));
    d.dst = int'($urandom_range(0, 3));
    d.ofs = int'($urandom_range(0, 63));
    d.base = base; d.len = len; d.kern = kern; d.stride = stride; d.pad = pad;
    return d;
  endfunction

  // Expected trace: index 0 is the cycle after the accepted start.
  function automatic void build_model(desc_t d, int abort_at);
    int   k = (d.kern == 0) ? 1 : d.kern;
    int   a;
    obs_t e, r;
    exp_q.delete();
    e = '0;
    e.busy = 1'b1; e.strd = (d.stride != 0); e.cfg = 4'(d.cfg); e.store = 8'(d.dst * 64 + d.ofs);
    if (d.len != 0) begin
      r = e; r.en = 1'b1;
      exp_q.push_back(r);
      for (int p = 0; p < ((d.stride != 0) ? 2 : 1); p++)
        for (int o = 0; o < d.len; o++)
          for (int j = 0; j < k; j++) begin
            r = e; r.en = 1'b1; r.ena = 1'b1; r.enb = 1'b1;
            r.pad = (d.pad != 0) && o == 0 && j == 0;
            r.incr = (j != 0);
            r.par = (p == 1);
            a = (d.base + o * (1 + d.stride) + j) % 64;
            r.addra = 8'(d.src * 64 + a);
            r.addrb = 8'(d.src * 64 + (a + 1) % 64);
            exp_q.push_back(r);
          end
      for (int i = 0; i < DRAIN; i++) begin
        r = e; r.en = 1'b1;
        exp_q.push_back(r);
      end
    end
    if (abort_at >= 0) begin
      while (exp_q.size() > abort_at + 1) void'(exp_q.pop_back());
      exp_q.push_back(e);
    end
    r = e; r.done = 1'b1; r.ldone = 1'b1;
    exp_q.push_back(r);
    exp_q.push_back('0);
    exp_q.push_back('0);
  endfunction

  // Address/parity only meaningful while reading; latched fields only while busy.
  function automatic obs_t sample();
    obs_t o = '0;
    o.busy = bus.busy_out; o.done = bus.done_out; o.ldone = bus.layer_done_out;
    o.en = bus.En_out; o.ena = bus.CTRL_LDM_ena_out; o.enb = bus.CTRL_LDM_enb_out;
    o.wea = bus.CTRL_LDM_wea_out; o.web = bus.CTRL_LDM_web_out;
    o.pad = bus.Padding_Read_out; o.incr = bus.CTRL_LDM_addra_Incr_out;
    if (bus.CTRL_LDM_ena_out) begin
      o.par = bus.Parity_PE_Selection_out;
      o.addra = bus.CTRL_LDM_addra_out; o.addrb = bus.CTRL_LDM_addrb_out;
    end
    if (bus.busy_out) begin
      o.strd = bus.Stride_out; o.cfg = bus.CFG_out; o.store = bus.CTRL_LDM_Store_out;
    end
    return o;
  endfunction

  task automatic drive_desc(desc_t d);
    bus.cfg_in = 4'(d.cfg); bus.src_bank_in = 2'(d.src); bus.dst_bank_in = 2'(d.dst);
    bus.store_ofs_in = 6'(d.ofs); bus.base_addr_in = 6'(d.base); bus.out_len_in = 6'(d.len);
    bus.kernel_in = 2'(d.kern); bus.stride_in = (d.stride != 0); bus.pad_in = (d.pad != 0);
  endtask

  // Drives one layer for the length of the expected trace; inputs scrambled after start.
  task automatic run_layer(desc_t d, int abort_at, int spur_at);
    build_model(d, abort_at);
    obs_q.delete();
    @(negedge clk);
    drive_desc(d);
    bus.start_in = 1'b1;
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      if (i == 0) drive_desc(make_desc(int'($urandom_range(0, 63)), int'($urandom_range(0, 63)),
                                       int'($urandom_range(0, 3)), int'($urandom_range(0, 1)),
                                       int'($urandom_range(0, 1))));
      bus.start_in = (i == spur_at);
      bus.abort_in = (i == abort_at);
      obs_q.push_back(sample());
    end
    bus.start_in = 1'b0;
    bus.abort_in = 1'b0;
  endtask

  function automatic logic [39:0] raw_outputs();
    return {bus.busy_out, bus.done_out, bus.En_out, bus.layer_done_out, bus.CFG_out,
            bus.Parity_PE_Selection_out, bus.Stride_out, bus.Padding_Read_out,
            bus.CTRL_LDM_addra_out, bus.CTRL_LDM_addrb_out, bus.CTRL_LDM_ena_out,
            bus.CTRL_LDM_enb_out, bus.CTRL_LDM_wea_out, bus.CTRL_LDM_web_out,
            bus.CTRL_LDM_Store_out, bus.CTRL_LDM_addra_Incr_out};
  endfunction

  task automatic test_reset();
    bus.start_in = 1'b0; bus.abort_in = 1'b0;
    drive_desc(make_desc(0, 0, 0, 0, 0));
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (raw_outputs() !== '0) begin
      bad++; $display("FAIL reset_outputs: got %h want 0", raw_outputs());
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_stride1_conv();
    int addr_exp[9] = '{4, 5, 6, 5, 6, 7, 6, 7, 8};
    int n = 0, last = -1, ld = -1;
    run_layer(make_desc(4, 3, 3, 0, 0), -1, -1);
    foreach (exp_q[i]) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin
        bad++; $display("FAIL conv_trace cyc%0d: got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    foreach (obs_q[i]) begin
      if (obs_q[i].ena) begin
        total++;
        if (n < 9 && (obs_q[i].addra[5:0] !== 6'(addr_exp[n]) || obs_q[i].incr !== (n % 3 != 0))) begin
          bad++; $display("FAIL conv_addr read%0d: got %0d/%b want %0d/%b", n,
                          obs_q[i].addra[5:0], obs_q[i].incr, addr_exp[n], n % 3 != 0);
        end
        n++; last = i;
      end
      if (obs_q[i].ldone && ld < 0) ld = i;
    end
    total++;
    if (n !== 9 || obs_q[1].ena !== 1'b1 || obs_q[0].ena !== 1'b0) begin
      bad++; $display("FAIL conv_ena: got count %0d first at1=%b want 9 with first read at 1", n,
                      obs_q[1].ena);
    end
    total++;
    if (ld - last !== DRAIN + 1) begin
      bad++; $display("FAIL conv_drain_latency: got %0d want %0d", ld - last, DRAIN + 1);
    end
  endtask

  task automatic test_stride2_passes();
    int n = 0;
    run_layer(make_desc(0, 2, 2, 1, 0), -1, -1);
    foreach (exp_q[i]) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin
        bad++; $display("FAIL stride2_trace cyc%0d: got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    for (int i = 1; i <= 8; i++) begin
      if (obs_q[i].ena && obs_q[i].strd && obs_q[i].par == (i > 4) &&
          obs_q[i].addra[5:0] == 6'((i - 1) % 4)) n++;
    end
    total++;
    if (n !== 8 || obs_q[9].ena !== 1'b0) begin
      bad++; $display("FAIL stride2_contiguous: got %0d good reads want 8", n);
    end
  endtask

  task automatic test_padding();
    int n = 0;
    run_layer(make_desc(10, 2, 3, 1, 1), -1, -1);
    foreach (exp_q[i]) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin
        bad++; $display("FAIL pad_trace cyc%0d: got %h want %h", i, obs_q[i], exp_q[i]);
      end
      if (obs_q[i].pad) n++;
    end
    total++;
    if (n !== 2 || obs_q[1].pad !== 1'b1 || obs_q[7].pad !== 1'b1) begin
      bad++; $display("FAIL pad_count: got %0d want 2 (cycles 1 and 7)", n);
    end
  endtask

  task automatic test_wrap_and_zero();
    int a_exp[4] = '{62, 63, 63, 0};
    int b_exp[4] = '{63, 0, 0, 1};
    int n = 0;
    run_layer(make_desc(62, 2, 2, 0, 0), -1, -1);
    foreach (exp_q[i]) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin
        bad++; $display("FAIL wrap_trace cyc%0d: got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (obs_q[i + 1].addra[5:0] !== 6'(a_exp[i]) || obs_q[i + 1].addrb[5:0] !== 6'(b_exp[i]))
      begin
        bad++; $display("FAIL wrap_addr read%0d: got %0d/%0d want %0d/%0d", i,
                        obs_q[i + 1].addra[5:0], obs_q[i + 1].addrb[5:0], a_exp[i], b_exp[i]);
      end
    end
    run_layer(make_desc(5, 0, 2, 0, 0), -1, -1);
    foreach (obs_q[i]) if (obs_q[i].ena || obs_q[i].en) n++;
    total++;
    if (obs_q[0].done !== 1'b1 || obs_q[0].ldone !== 1'b1 || n !== 0 || obs_q[1].busy !== 1'b0)
    begin
      bad++; $display("FAIL zero_len: got done=%b reads=%0d busy1=%b want done=1 reads=0 busy1=0",
                      obs_q[0].done, n, obs_q[1].busy);
    end
  endtask

  task automatic test_abort();
    // abort during the third read; a spurious start during the first reads is ignored
    run_layer(make_desc(7, 4, 3, 0, 1), 3, 2);
    foreach (exp_q[i]) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin
        bad++; $display("FAIL abort_trace cyc%0d: got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    total++;
    if (obs_q[3].ena !== 1'b1 || obs_q[4].ena !== 1'b0 || obs_q[4].en !== 1'b0 ||
        obs_q[5].ldone !== 1'b1 || obs_q[6].busy !== 1'b0) begin
      bad++; $display("FAIL abort_timing: got ena3=%b ena4=%b en4=%b ld5=%b busy6=%b want 1 0 0 1 0",
                      obs_q[3].ena, obs_q[4].ena, obs_q[4].en, obs_q[5].ldone, obs_q[6].busy);
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    drive_desc(make_desc(20, 5, 3, 1, 1));
    bus.start_in = 1'b1;
    @(negedge clk);
    bus.start_in = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (bus.CTRL_LDM_ena_out !== 1'b1) begin
      bad++; $display("FAIL async_pre_run: got ena=%b want 1", bus.CTRL_LDM_ena_out);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (raw_outputs() !== '0) begin
      bad++; $display("FAIL async_reset_outputs: got %h want 0", raw_outputs());
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_layer(make_desc(33, 3, 2, 1, 1), -1, -1);
    foreach (exp_q[i]) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin
        bad++; $display("FAIL post_reset_trace cyc%0d: got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_random();
    desc_t d;
    int r, ab, sp, last;
    for (int it = 0; it < 30; it++) begin
      d = make_desc(int'($urandom_range(0, 63)), int'($urandom_range(1, 6)),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 1)),
                    int'($urandom_range(0, 1)));
      if (it == 7) d.len = 63;
      if ($urandom_range(0, 7) == 0) d.len = 0;
      r = d.len * ((d.kern == 0) ? 1 : d.kern) * (1 + d.stride);
      ab = (d.len != 0 && $urandom_range(0, 2) == 0) ? int'($urandom_range(0, r + DRAIN)) : -1;
      last = (d.len == 0) ? 0 : ((ab >= 0) ? ab + 2 : r + DRAIN + 1);
      sp = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, last)) : -1;
      run_layer(d, ab, sp);
      foreach (exp_q[i]) begin
        total++;
        if (obs_q[i] !== exp_q[i]) begin
          bad++; $display("FAIL random_trace it%0d cyc%0d: got %h want %h", it, i, obs_q[i],
                          exp_q[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_stride1_conv();
    test_stride2_passes();
    test_padding();
    test_wrap_and_zero();
    test_abort();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
